dram_arbiter: RTL

Two-port round-robin arbiter that shares the single DRAM command interface (32-bit command address, 144-bit/18-byte-enable two-word bursts) between two requesters. It issues each granted command and owns the burst's second beat. It routes the two-beat read returns back to the issuing port using an in-order tag FIFO. It sits between the application-side DRAM users and the DRAM controller, in the `dram_clk` domain.

---
 rtl/dram_arb_pkg.sv | 30 +++
 rtl/dram_arbiter_if.sv | 54 +++++
 rtl/dram_arb_tag_fifo.sv | 63 ++++++
 rtl/dram_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-port DRAM command arbiter.
// Build option DRAM_ARB_FIXED_PRIO_EN is consumed by dram_arbiter.
package dram_arb_pkg;

  localparam int unsigned DRAM_ADDR_W = 32;
  localparam int unsigned DRAM_DATA_W = 144;
  localparam int unsigned DRAM_BE_W   = 18;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef enum logic {
    ISSUE = 1'b0,
    BEAT1 = 1'b1
  } arb_state_e;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  function automatic port_id_t rr_pick(input logic req0, input logic req1, input port_id_t last);
    if (req0 && req1) begin
      return ~last;
    end else if (req1) begin
      return PORT1;
    end else begin
      return PORT0;
    end
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two DRAM requesters, the arbiter and the DRAM controller.
// slave = arbiter view, master = environment (requesters + controller) view.
interface dram_arbiter_if;
  import dram_arb_pkg::*;

  logic                   p0_cmd_valid;
  logic [DRAM_ADDR_W-1:0] p0_cmd_addr;
  logic                   p0_cmd_rnw;
  logic [DRAM_DATA_W-1:0] p0_wr_data;
  logic [DRAM_BE_W-1:0]   p0_wr_be;
  logic                   p0_cmd_ack;
  logic [DRAM_DATA_W-1:0] p0_rd_data;
  logic                   p0_rd_valid;

  logic                   p1_cmd_valid;
  logic [DRAM_ADDR_W-1:0] p1_cmd_addr;
  logic                   p1_cmd_rnw;
  logic [DRAM_DATA_W-1:0] p1_wr_data;
  logic [DRAM_BE_W-1:0]   p1_wr_be;
  logic                   p1_cmd_ack;
  logic [DRAM_DATA_W-1:0] p1_rd_data;
  logic                   p1_rd_valid;

  logic [DRAM_ADDR_W-1:0] dram_cmd_addr;
  logic                   dram_cmd_rnw;
  logic                   dram_cmd_valid;
  logic [DRAM_DATA_W-1:0] dram_wr_data;
  logic [DRAM_BE_W-1:0]   dram_wr_be;
  logic [DRAM_DATA_W-1:0] dram_rd_data;
  logic                   dram_rd_valid;
  logic                   dram_ready;
  logic                   arb_err;

  modport slave (
    input  p0_cmd_valid, p0_cmd_addr, p0_cmd_rnw, p0_wr_data, p0_wr_be,
    input  p1_cmd_valid, p1_cmd_addr, p1_cmd_rnw, p1_wr_data, p1_wr_be,
    input  dram_rd_data, dram_rd_valid, dram_ready,
    output p0_cmd_ack, p0_rd_data, p0_rd_valid,
    output p1_cmd_ack, p1_rd_data, p1_rd_valid,
    output dram_cmd_addr, dram_cmd_rnw, dram_cmd_valid, dram_wr_data, dram_wr_be,
    output arb_err
  );

  modport master (
    output p0_cmd_valid, p0_cmd_addr, p0_cmd_rnw, p0_wr_data, p0_wr_be,
    output p1_cmd_valid, p1_cmd_addr, p1_cmd_rnw, p1_wr_data, p1_wr_be,
    output dram_rd_data, dram_rd_valid, dram_ready,
    input  p0_cmd_ack, p0_rd_data, p0_rd_valid,
    input  p1_cmd_ack, p1_rd_data, p1_rd_valid,
    input  dram_cmd_addr, dram_cmd_rnw, dram_cmd_valid, dram_wr_data, dram_wr_be,
    input  arb_err
  );

endinterface

// File: rtl/dram_arb_tag_fifo.sv
// In-order FIFO of issuing-port tags for outstanding read bursts.
// Push while full is accepted only together with a pop (occupancy unchanged).
module dram_arb_tag_fifo
  import dram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  port_id_t push_id,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  port_id_t         mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == {CNT_W{1'b0}});
    head      = mem_r[rd_ptr_r];
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_id;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter for the DRAM command interface, with tag-routed read returns.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = 32
) (
  input  logic          dram_clk,
  input  logic          dram_rst,
  dram_arbiter_if.slave bus
);

  arb_state_e             state_r;
  arb_state_e             state_s;
  port_id_t               owner_r;
  logic                   rnw_r;
  port_id_t               winner_s;
  port_id_t               sel_s;
  logic                   elig0_s;
  logic                   elig1_s;
  logic                   grant_s;
  logic [DRAM_ADDR_W-1:0] sel_addr_s;
  logic                   sel_rnw_s;
  logic [DRAM_DATA_W-1:0] sel_data_s;
  logic [DRAM_BE_W-1:0]   sel_be_s;
  logic                   tag_full_s;
  logic                   tag_empty_s;
  port_id_t               tag_head_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   rd_hit_s;
  logic                   beat_r;
  logic                   arb_err_r;
`ifndef DRAM_ARB_FIXED_PRIO_EN
  port_id_t               last_r;
`endif

  // Eligibility: a full tag FIFO blocks reads only; nothing issues under reset.
  always_comb begin
    elig0_s = 1'b0;
    elig1_s = 1'b0;
    if (!dram_rst && (state_r == ISSUE) && bus.dram_ready) begin
      elig0_s = bus.p0_cmd_valid && (!bus.p0_cmd_rnw || !tag_full_s);
      elig1_s = bus.p1_cmd_valid && (!bus.p1_cmd_rnw || !tag_full_s);
    end else begin
      elig0_s = 1'b0;
      elig1_s = 1'b0;
    end
  end

  always_comb begin
    winner_s = PORT0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    if (elig0_s) begin
      winner_s = PORT0;
    end else if (elig1_s) begin
      winner_s = PORT1;
    end else begin
      winner_s = PORT0;
    end
`else
    winner_s = rr_pick(elig0_s, elig1_s, last_r);
`endif
  end

  // FSM next state and port select; BEAT1 always follows an issue.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    sel_s   = PORT0;
    case (state_r)
      ISSUE: begin
        sel_s = winner_s;
        if (elig0_s || elig1_s) begin
          grant_s = 1'b1;
          state_s = BEAT1;
        end else begin
          grant_s = 1'b0;
          state_s = ISSUE;
        end
      end
      BEAT1: begin
        sel_s   = owner_r;
        state_s = ISSUE;
      end
      default: begin
        sel_s   = PORT0;
        state_s = ISSUE;
      end
    endcase
  end

  always_comb begin
    sel_addr_s = bus.p0_cmd_addr;
    sel_rnw_s  = bus.p0_cmd_rnw;
    sel_data_s = bus.p0_wr_data;
    sel_be_s   = bus.p0_wr_be;
    if (sel_s == PORT1) begin
      sel_addr_s = bus.p1_cmd_addr;
      sel_rnw_s  = bus.p1_cmd_rnw;
      sel_data_s = bus.p1_wr_data;
      sel_be_s   = bus.p1_wr_be;
    end else begin
      sel_addr_s = bus.p0_cmd_addr;
      sel_rnw_s  = bus.p0_cmd_rnw;
      sel_data_s = bus.p0_wr_data;
      sel_be_s   = bus.p0_wr_be;
    end
  end

  // Command outputs; the second beat of a read carries no byte enables.
  always_comb begin
    bus.dram_cmd_valid = grant_s;
    bus.dram_cmd_addr  = sel_addr_s;
    bus.dram_wr_data   = sel_data_s;
    bus.p0_cmd_ack     = grant_s && (sel_s == PORT0);
    bus.p1_cmd_ack     = grant_s && (sel_s == PORT1);
    push_s             = grant_s && sel_rnw_s;
    if (state_r == BEAT1) begin
      bus.dram_cmd_rnw = rnw_r;
      bus.dram_wr_be   = rnw_r ? {DRAM_BE_W{1'b0}} : sel_be_s;
    end else begin
      bus.dram_cmd_rnw = sel_rnw_s;
      bus.dram_wr_be   = sel_be_s;
    end
  end

  always_comb begin
    rd_hit_s        = bus.dram_rd_valid && !tag_empty_s && !dram_rst;
    pop_s           = rd_hit_s && beat_r;
    bus.p0_rd_valid = rd_hit_s && (tag_head_s == PORT0);
    bus.p1_rd_valid = rd_hit_s && (tag_head_s == PORT1);
    bus.p0_rd_data  = bus.dram_rd_data;
    bus.p1_rd_data  = bus.dram_rd_data;
    bus.arb_err     = arb_err_r;
  end

  // FSM state plus burst owner captured on the issue edge.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      state_r <= ISSUE;
      owner_r <= PORT0;
      rnw_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        owner_r <= winner_s;
        rnw_r   <= sel_rnw_s;
      end
    end
  end

`ifndef DRAM_ARB_FIXED_PRIO_EN
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      last_r <= PORT1;
    end else if (grant_s) begin
      last_r <= winner_s;
    end
  end
`endif

  // Return beat parity and the sticky orphan-return flag.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      beat_r    <= 1'b0;
      arb_err_r <= 1'b0;
    end else begin
      if (rd_hit_s) begin
        beat_r <= ~beat_r;
      end
      if (bus.dram_rd_valid && tag_empty_s) begin
        arb_err_r <= 1'b1;
      end
    end
  end

  dram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (dram_clk),
    .rst     (dram_rst),
    .push    (push_s),
    .pop     (pop_s),
    .push_id (winner_s),
    .full    (tag_full_s),
    .empty   (tag_empty_s),
    .head    (tag_head_s)
  );

endmodule
